// File: rtl/rr_arb_mux.sv
// N-input valid/ready arbiter (round-robin or fixed-priority) feeding a single
// registered output stage; one word per cycle when the consumer keeps up.
module rr_arb_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 4,
    parameter int SEL_WIDTH  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    input  logic                         mode,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_WIDTH-1:0]         out_sel,
    output logic                         out_valid,
    input  logic                         out_ready
);

    logic [DATA_WIDTH-1:0] in_word [NUM_IN];

    logic                  load_en;
    logic                  accept;
    logic                  grant_vld;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic [SEL_WIDTH-1:0]  low_idx;
    logic [SEL_WIDTH-1:0]  hi_idx;
    logic                  hi_found;

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0]  out_sel_q, out_sel_d;
    logic                  out_valid_q, out_valid_d;
    logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

    assign load_en = !out_valid_q || out_ready;

    // Round-robin search is split into "lowest valid at or above rr_ptr" and
    // "lowest valid overall" so the wrap never needs a variable rotate.
    always_comb begin
        grant_vld = |in_valid;
        low_idx   = '0;
        hi_idx    = '0;
        hi_found  = 1'b0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                low_idx = SEL_WIDTH'(i);
            end
            if (in_valid[i] && (i >= int'(rr_ptr_q))) begin
                hi_idx   = SEL_WIDTH'(i);
                hi_found = 1'b1;
            end
        end
        grant_idx = (!mode && hi_found) ? hi_idx : low_idx;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_ch
            assign in_word[gi]  = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign in_ready[gi] = rst_n && load_en && grant_vld &&
                                  (grant_idx == SEL_WIDTH'(gi));
        end
    endgenerate

    assign accept = grant_vld && load_en;

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            out_valid_d = accept;
        end
        if (accept) begin
            out_data_d = in_word[grant_idx];
            out_sel_d  = grant_idx;
            if (!mode) begin
                rr_ptr_d = (grant_idx == SEL_WIDTH'(NUM_IN - 1)) ? '0
                         : grant_idx + SEL_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: 4-, 3- and 1-input instances sharing clock and reset.
module tb_rr_arb_mux;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4*DW-1:0] d4;  logic [3:0] v4, r4;  logic m4, ordy4, ov4;
    logic [DW-1:0]   od4; logic [1:0] os4;
    logic [3*DW-1:0] d3;  logic [2:0] v3, r3;  logic m3, ordy3, ov3;
    logic [DW-1:0]   od3; logic [1:0] os3;
    logic [DW-1:0]   d1;  logic [0:0] v1, r1;  logic m1, ordy1, ov1;
    logic [DW-1:0]   od1; logic [0:0] os1;

    rr_arb_mux #(.DATA_WIDTH(DW), .NUM_IN(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_ready(r4),
        .mode(m4), .out_data(od4), .out_sel(os4), .out_valid(ov4), .out_ready(ordy4));
    rr_arb_mux #(.DATA_WIDTH(DW), .NUM_IN(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_ready(r3),
        .mode(m3), .out_data(od3), .out_sel(os3), .out_valid(ov3), .out_ready(ordy3));
    rr_arb_mux #(.DATA_WIDTH(DW), .NUM_IN(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1), .in_ready(r1),
        .mode(m1), .out_data(od1), .out_sel(os1), .out_valid(ov1), .out_ready(ordy1));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp3 [4];
        exp3 = '{2, 0, 2, 0};
        d4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0}; v4 = 4'hF; m4 = 1'b0; ordy4 = 1'b1;
        d3 = {32'hB2, 32'hB1, 32'hB0};         v3 = '0;   m3 = 1'b0; ordy3 = 1'b1;
        d1 = 32'h1234;                         v1 = '0;   m1 = 1'b0; ordy1 = 1'b1;

        // reset state, inputs already valid
        #12;
        chk("rst out_valid", ov4, 0);
        chk("rst out_data", od4, 0);
        chk("rst out_sel", os4, 0);
        chk("rst in_ready", r4, 0);
        rst_n = 1'b1;
        #1;
        chk("rr first in_ready", r4, 4'b0001);

        // round-robin, all valid, 10 transfers (leaves rr_ptr at 2)
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("rr%0d out_sel", c), os4, c % 4);
            chk($sformatf("rr%0d out_data", c), od4, 32'hA0 + c % 4);
            chk($sformatf("rr%0d out_valid", c), ov4, 1);
            chk($sformatf("rr%0d in_ready", c), r4, 1 << ((c + 1) % 4));
        end

        // fixed priority: channel 0 always, rr_ptr untouched
        m4 = 1'b1;
        #1;
        chk("fp in_ready", r4, 4'b0001);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("fp%0d out_sel", c), os4, 0);
            chk($sformatf("fp%0d out_data", c), od4, 32'hA0);
            chk($sformatf("fp%0d in_ready", c), r4, 4'b0001);
        end
        m4 = 1'b0;
        #1;
        chk("mode switch keeps rr_ptr", r4, 4'b0100);
        v4 = 4'h0;
        #1;
        chk("idle in_ready", r4, 0);
        tick();
        chk("drain out_valid", ov4, 0);

        // stall with only channel 2 valid
        d4[2*DW +: DW] = 32'h55;
        v4 = 4'b0100;
        ordy4 = 1'b0;
        #1;
        chk("stall load in_ready", r4, 4'b0100);
        tick();
        chk("stall load out_valid", ov4, 1);
        chk("stall load out_data", od4, 32'h55);
        chk("stall load out_sel", os4, 2);
        d4[2*DW +: DW] = 32'h66;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d in_ready", c), r4, 0);
            tick();
            chk($sformatf("stall%0d out_valid", c), ov4, 1);
            chk($sformatf("stall%0d out_data", c), od4, 32'h55);
            chk($sformatf("stall%0d out_sel", c), os4, 2);
        end
        ordy4 = 1'b1;
        #1;
        chk("release in_ready", r4, 4'b0100);
        tick();
        chk("release out_data", od4, 32'h66);
        chk("release out_sel", os4, 2);
        v4 = 4'h0;
        tick();
        chk("release drain out_valid", ov4, 0);

        // async reset mid-stream (rr_ptr 3 -> grants 3, 0, then reset)
        d4[2*DW +: DW] = 32'hA2;
        v4 = 4'hF;
        #1;
        chk("pre-rst in_ready", r4, 4'b1000);
        tick();
        chk("pre-rst out_sel a", os4, 3);
        chk("pre-rst out_data a", od4, 32'hA3);
        tick();
        chk("pre-rst out_sel b", os4, 0);
        chk("pre-rst in_ready b", r4, 4'b0010);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", ov4, 0);
        chk("async rst out_data", od4, 0);
        chk("async rst in_ready", r4, 0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("post-rst in_ready", r4, 4'b0001);
        tick();
        chk("post-rst out_sel", os4, 0);
        chk("post-rst out_data", od4, 32'hA0);
        v4 = 4'h0;
        tick();

        // NUM_IN=3 wrap: move pointer to 2, then alternate 2,0,2,0
        v3 = 3'b010;
        #1;
        chk("n3 in_ready ch1", r3, 3'b010);
        tick();
        chk("n3 out_sel ch1", os3, 1);
        v3 = 3'b101;
        #1;
        chk("n3 in_ready start", r3, 3'b100);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("n3 %0d out_sel", c), os3, exp3[c]);
            chk($sformatf("n3 %0d out_data", c), od3, 32'hB0 + exp3[c]);
            chk($sformatf("n3 %0d in_ready", c), r3, (exp3[c] == 2) ? 3'b001 : 3'b100);
        end
        v3 = 3'b000;
        tick();
        chk("n3 drain out_valid", ov3, 0);

        // NUM_IN=1 single pulse
        v1 = 1'b1;
        #1;
        chk("n1 in_ready", r1, 1);
        tick();
        v1 = 1'b0;
        chk("n1 out_valid", ov1, 1);
        chk("n1 out_data", od1, 32'h1234);
        chk("n1 out_sel", os1, 0);
        tick();
        chk("n1 out_valid off", ov1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
